// File: rtl/issue_dispatcher_pkg.sv
// Shared types and constants for the single-issue dispatch stage.
// Covers the instruction holding register, FSM states and unit encodings.
package issue_dispatcher_pkg;

    localparam int   OP_W     = 6;
    localparam int   REG_W    = 5;
    localparam logic TRUE     = 1'b1;
    localparam logic FALSE    = 1'b0;
    localparam logic UNIT_ALU = 1'b0;
    localparam logic UNIT_LSB = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } disp_state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             unit;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             use1;
        logic             use2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic             pred;
    } instr_t;

endpackage

// File: rtl/issue_dispatcher_operand_resolve.sv
// Priority mux that resolves one source operand from the register file,
// the CDB broadcast or the ROB; unused operands and x0 resolve ready with 0.
module issue_dispatcher_operand_resolve
    import issue_dispatcher_pkg::*;
#(
    parameter int ROB_W = 4
) (
    input  logic             use_op,
    input  logic [REG_W-1:0] idx,
    input  logic [ROB_W-1:0] rf_q,
    input  logic [31:0]      rf_v,
    input  logic             rf_r,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             rob_rdy,
    input  logic [31:0]      rob_val,
    output logic [ROB_W-1:0] q,
    output logic [31:0]      v,
    output logic             r
);

    // First matching source wins; tag is only kept while still waiting
    always_comb begin
        q = {ROB_W{1'b0}};
        v = 32'd0;
        r = FALSE;
        if (!use_op || idx == 5'd0) begin
            r = TRUE;
        end else if (rf_r) begin
            r = TRUE;
            v = rf_v;
        end else if (cdb_valid && cdb_tag == rf_q) begin
            r = TRUE;
            v = cdb_val;
        end else if (rob_rdy) begin
            r = TRUE;
            v = rob_val;
        end else begin
            q = rf_q;
        end
    end

endmodule

// File: rtl/issue_dispatcher.sv
// Single-issue dispatch stage: holds one instruction, resolves operands,
// renames rd, allocates a ROB entry and hands off to the ALU RS or the LSB.
module issue_dispatcher
    import issue_dispatcher_pkg::*;
#(
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             iq_valid,
    output logic             iq_ready,
    input  logic [OP_W-1:0]  iq_op,
    input  logic             iq_unit,
    input  logic [4:0]       iq_rs1,
    input  logic [4:0]       iq_rs2,
    input  logic [4:0]       iq_rd,
    input  logic             iq_use1,
    input  logic             iq_use2,
    input  logic [31:0]      iq_imm,
    input  logic [31:0]      iq_pc,
    input  logic             iq_pred,
    output logic             rf_query_valid,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    output logic [4:0]       rf_rd,
    input  logic [ROB_W-1:0] rf_Qj,
    input  logic [ROB_W-1:0] rf_Qk,
    input  logic [31:0]      rf_Vj,
    input  logic [31:0]      rf_Vk,
    input  logic             rf_Rj,
    input  logic             rf_Rk,
    output logic             rf_rename_valid,
    output logic [ROB_W-1:0] rf_rd_tag,
    input  logic             rob_full,
    input  logic [ROB_W-1:0] rob_free_tag,
    output logic [ROB_W-1:0] rob_q1_tag,
    output logic [ROB_W-1:0] rob_q2_tag,
    input  logic             rob_q1_rdy,
    input  logic             rob_q2_rdy,
    input  logic [31:0]      rob_q1_val,
    input  logic [31:0]      rob_q2_val,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic             rob_alloc,
    output logic             rs_valid,
    output logic             lsb_valid,
    output logic [OP_W-1:0]  d_op,
    output logic [ROB_W-1:0] d_Qj,
    output logic [ROB_W-1:0] d_Qk,
    output logic [31:0]      d_Vj,
    output logic [31:0]      d_Vk,
    output logic             d_Rj,
    output logic             d_Rk,
    output logic [4:0]       d_rd,
    output logic [ROB_W-1:0] d_tag,
    output logic [31:0]      d_imm,
    output logic [31:0]      d_pc,
    output logic             d_pred,
    output logic [31:0]      stall_cnt
);

    disp_state_e      state_r;
    instr_t           h_r;
    instr_t           iq_instr_s;
    logic             h_valid_s;
    logic             target_full_s;
    logic             fire_s;
    logic             accept_s;
    logic [ROB_W-1:0] qj_s, qk_s;
    logic [31:0]      vj_s, vk_s;
    logic             rj_s, rk_s;

    assign h_valid_s     = (state_r == ST_HELD);
    assign target_full_s = (h_r.unit == UNIT_LSB) ? lsb_full : rs_full;
    assign fire_s        = rdy && h_valid_s && !rollback && !rob_full && !target_full_s;
    assign iq_ready      = rdy && !rollback && (!h_valid_s || fire_s);
    assign accept_s      = iq_valid && iq_ready;

    assign rf_query_valid  = h_valid_s;
    assign rf_rs1          = h_r.rs1;
    assign rf_rs2          = h_r.rs2;
    assign rf_rd           = h_r.rd;
    assign rob_q1_tag      = rf_Qj;
    assign rob_q2_tag      = rf_Qk;
    assign rf_rename_valid = fire_s && (h_r.rd != 5'd0);
    assign rf_rd_tag       = rob_free_tag;

    // Pack the incoming queue entry into the holding-register layout
    always_comb begin
        iq_instr_s      = '{default: 1'b0};
        iq_instr_s.op   = iq_op;
        iq_instr_s.unit = iq_unit;
        iq_instr_s.rs1  = iq_rs1;
        iq_instr_s.rs2  = iq_rs2;
        iq_instr_s.rd   = iq_rd;
        iq_instr_s.use1 = iq_use1;
        iq_instr_s.use2 = iq_use2;
        iq_instr_s.imm  = iq_imm;
        iq_instr_s.pc   = iq_pc;
        iq_instr_s.pred = iq_pred;
    end

    issue_dispatcher_operand_resolve #(.ROB_W(ROB_W)) u_res_j (
        .use_op   (h_r.use1),   .idx     (h_r.rs1),
        .rf_q     (rf_Qj),      .rf_v    (rf_Vj),      .rf_r    (rf_Rj),
        .cdb_valid(cdb_valid),  .cdb_tag (cdb_tag),    .cdb_val (cdb_val),
        .rob_rdy  (rob_q1_rdy), .rob_val (rob_q1_val),
        .q        (qj_s),       .v       (vj_s),       .r       (rj_s)
    );

    issue_dispatcher_operand_resolve #(.ROB_W(ROB_W)) u_res_k (
        .use_op   (h_r.use2),   .idx     (h_r.rs2),
        .rf_q     (rf_Qk),      .rf_v    (rf_Vk),      .rf_r    (rf_Rk),
        .cdb_valid(cdb_valid),  .cdb_tag (cdb_tag),    .cdb_val (cdb_val),
        .rob_rdy  (rob_q2_rdy), .rob_val (rob_q2_val),
        .q        (qk_s),       .v       (vk_s),       .r       (rk_s)
    );

    // Holding-register FSM, registered dispatch bundle and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_EMPTY;
            h_r       <= '{default: 1'b0};
            rob_alloc <= 1'b0;
            rs_valid  <= 1'b0;
            lsb_valid <= 1'b0;
            d_op      <= {OP_W{1'b0}};
            d_Qj      <= {ROB_W{1'b0}};
            d_Qk      <= {ROB_W{1'b0}};
            d_Vj      <= 32'd0;
            d_Vk      <= 32'd0;
            d_Rj      <= 1'b0;
            d_Rk      <= 1'b0;
            d_rd      <= 5'd0;
            d_tag     <= {ROB_W{1'b0}};
            d_imm     <= 32'd0;
            d_pc      <= 32'd0;
            d_pred    <= 1'b0;
            stall_cnt <= 32'd0;
        end else if (rdy) begin
            if (h_valid_s && !fire_s) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (rollback) begin
                state_r   <= ST_EMPTY;
                rob_alloc <= 1'b0;
                rs_valid  <= 1'b0;
                lsb_valid <= 1'b0;
            end else begin
                rob_alloc <= fire_s;
                rs_valid  <= fire_s && (h_r.unit == UNIT_ALU);
                lsb_valid <= fire_s && (h_r.unit == UNIT_LSB);
                if (fire_s) begin
                    d_op   <= h_r.op;
                    d_Qj   <= qj_s;
                    d_Qk   <= qk_s;
                    d_Vj   <= vj_s;
                    d_Vk   <= vk_s;
                    d_Rj   <= rj_s;
                    d_Rk   <= rk_s;
                    d_rd   <= h_r.rd;
                    d_tag  <= rob_free_tag;
                    d_imm  <= h_r.imm;
                    d_pc   <= h_r.pc;
                    d_pred <= h_r.pred;
                end
                case (state_r)
                    ST_EMPTY: begin
                        if (accept_s) begin
                            h_r     <= iq_instr_s;
                            state_r <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (accept_s) begin
                            h_r <= iq_instr_s;
                        end else if (fire_s) begin
                            state_r <= ST_EMPTY;
                        end
                    end
                    default: state_r <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule
